// File: rtl/mcb_rr_drain.sv
// Round-robin drain of NUM_CH single-clock FIFOs into a tagged valid/ready stream.
// Optional per-channel delivered-word counters are built when MCB_RD_STATS_EN is defined.
module mcb_rr_drain #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned BURST_MAX  = 4
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]       ch_usedw,
   output logic [NUM_CH-1:0]                              ch_rd_en,
   input  logic [NUM_CH*DATA_WIDTH-1:0]                   ch_data,
   output logic                                           m_valid,
   input  logic                                           m_ready,
   output logic [DATA_WIDTH-1:0]                          m_data,
   output logic [$clog2(NUM_CH)-1:0]                      m_chan,
   output logic                                           m_last,
   output logic [NUM_CH*16-1:0]                           stat_words
);

   localparam int unsigned UW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned CW = $clog2(NUM_CH);
   localparam int unsigned BW = $clog2(BURST_MAX + 1);

   typedef enum logic {StArb, StBurst} state_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [CW-1:0]         chan;
      logic                  last;
   } ent_t;

   state_e        state_q, state_d;
   logic [CW-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0] gnt_q, gnt_d;
   logic [BW-1:0] burst_cnt_q, burst_cnt_d;
   logic          infl_q, infl_d;
   logic [CW-1:0] infl_chan_q, infl_chan_d;
   logic          infl_last_q, infl_last_d;
   logic [1:0]    occ_q, occ_d;
   ent_t          head_q, head_d;
   ent_t          tail_q, tail_d;

   logic [NUM_CH-1:0] nonempty;
   logic [UW-1:0]     gnt_usedw;
   logic              found;
   logic [CW-1:0]     pick;
   logic              hs;
   logic              credit;
   logic              issue;
   logic              last_tag;
   ent_t              cap;

   always_comb begin
      nonempty = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         nonempty[i] = (ch_usedw[i*UW +: UW] != '0);
      end
      found = 1'b0;
      pick  = '0;
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
         if (!found && nonempty[(32'(rr_ptr_q) + k) % NUM_CH]) begin
            found = 1'b1;
            pick  = CW'((32'(rr_ptr_q) + k) % NUM_CH);
         end
      end
   end

   assign gnt_usedw = ch_usedw[gnt_q*UW +: UW];
   assign hs        = (occ_q != 2'd0) && m_ready;
   // Words already buffered or in flight, less the one leaving this cycle, must leave a free slot.
   assign credit    = (({1'b0, occ_q} + {2'b0, infl_q} - {2'b0, hs}) < 3'd2);
   assign issue     = (state_q == StBurst) && (gnt_usedw != '0) && credit && !reset;
   assign last_tag  = (burst_cnt_q == BW'(BURST_MAX - 1)) || (gnt_usedw == UW'(1));
   assign ch_rd_en  = issue ? (NUM_CH'(1) << gnt_q) : '0;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_d       = gnt_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         StArb: begin
            if (found) begin
               gnt_d       = pick;
               burst_cnt_d = '0;
               state_d     = StBurst;
            end
         end
         StBurst: begin
            if (gnt_usedw == '0) begin
               rr_ptr_d = gnt_q;
               state_d  = StArb;
            end else if (issue) begin
               burst_cnt_d = burst_cnt_q + BW'(1);
               if (last_tag) begin
                  rr_ptr_d = gnt_q;
                  state_d  = StArb;
               end
            end
         end
         default: state_d = StArb;
      endcase
   end

   always_comb begin
      infl_d      = issue;
      infl_chan_d = issue ? gnt_q : infl_chan_q;
      infl_last_d = issue ? last_tag : infl_last_q;
      cap.data    = ch_data[infl_chan_q*DATA_WIDTH +: DATA_WIDTH];
      cap.chan    = infl_chan_q;
      cap.last    = infl_last_q;
      head_d      = head_q;
      tail_d      = tail_q;
      occ_d       = occ_q;
      case ({infl_q, hs})
         2'b10: begin
            if (occ_q == 2'd0) head_d = cap;
            else               tail_d = cap;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               head_d = cap;
            end else begin
               head_d = tail_q;
               tail_d = cap;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StArb;
         rr_ptr_q    <= CW'(NUM_CH - 1);
         gnt_q       <= '0;
         burst_cnt_q <= '0;
         infl_q      <= 1'b0;
         infl_chan_q <= '0;
         infl_last_q <= 1'b0;
         occ_q       <= 2'd0;
         head_q      <= '0;
         tail_q      <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_q       <= gnt_d;
         burst_cnt_q <= burst_cnt_d;
         infl_q      <= infl_d;
         infl_chan_q <= infl_chan_d;
         infl_last_q <= infl_last_d;
         occ_q       <= occ_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
      end
   end

   assign m_valid = (occ_q != 2'd0);
   assign m_data  = head_q.data;
   assign m_chan  = head_q.chan;
   assign m_last  = head_q.last;

`ifdef MCB_RD_STATS_EN
   logic [15:0] stat_q [NUM_CH];
   logic [15:0] stat_d [NUM_CH];

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         stat_d[i] = stat_q[i];
         if (hs && (m_chan == CW'(i)) && (stat_q[i] != 16'hFFFF)) begin
            stat_d[i] = stat_q[i] + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (reset) stat_q[i] <= 16'd0;
         else       stat_q[i] <= stat_d[i];
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
      assign stat_words[g*16 +: 16] = stat_q[g];
   end
`else
   assign stat_words = '0;
`endif

endmodule
